fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
- Instruction-fetch controller in front of the word-addressed, combinational-read instruction memory (1024 x 32).
- Owns the program counter and drives the memory address every cycle.
- Registers the returned word into the IF/ID stage with a valid/ready handshake.
- Handles branch/jump redirects, downstream stalls and fetch faults. Sits between instruction memory and the decode stage.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- IMEM_WORDS, 1024: instruction memory depth in words. Legal byte addresses are 0 .. IMEM_WORDS*4-4.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- pc_address  out  32  byte address to instruction memory; always equals current PC
- instruction  in  32  combinational read data from instruction memory
- redirect_valid  in  1  execute stage requests a PC change this cycle
- redirect_pc  in  32  target byte address for the redirect
- id_ready  in  1  decode stage can accept a word this cycle
- id_valid  out  1  id_instr/id_pc hold a valid fetched instruction
- id_instr  out  32  registered instruction word
- id_pc  out  32  PC of id_instr
- fetch_fault  out  1  sticky fault flag (misaligned or out-of-range PC)

Behaviour:
- Reset is synchronous and active-high. At reset, all outputs and state take these values:
  - pc = RESET_PC
  - id_valid = 0, id_instr = 0, id_pc = 0
  - fetch_fault = 0
  - state = BOOT
- Reset asserted mid-operation discards any held instruction and any pending redirect.
- State machine:
  - BOOT: one cycle, no fetch, pc_address = pc. Next state is RUN.
  - RUN: normal fetch.
  - FAULT: terminal until reset. id_valid = 0, pc frozen, fetch_fault = 1.
- pc_address = pc, combinationally, in every state.
- Fire condition in RUN: fire = !redirect_valid && (!id_valid || id_ready) && pc_in_range && pc[1:0] == 0.
- On fire, in the same edge:
  - id_instr <= instruction, id_pc <= pc, id_valid <= 1
  - pc <= pc + 4
- Latency: one cycle from the PC being presented to id_valid.
- Sustained throughput is one instruction per cycle while id_ready stays high.
- Stall: if id_valid && !id_ready, then id_valid, id_instr, id_id_pc... (id_instr, id_pc) and pc all hold. Outputs must stay stable until accepted.
- Drain: if id_valid && id_ready and fire is false (fault pending), id_valid <= 0.
- Redirect has the highest priority in RUN, regardless of id_ready:
  - id_valid <= 0 (the in-flight word is flushed)
  - pc <= redirect_pc
  - No fetch occurs in the redirect cycle. The first fetch from the target happens the next cycle.
- Fault detection, checked in RUN on the current pc when no redirect is asserted:
  - pc[1:0] != 0, or pc >= IMEM_WORDS*4, gives next state FAULT and fetch_fault <= 1.
  - Any valid instruction already in id_* must be accepted first. The fault is raised only once id_valid == 0 or id_ready == 1.
- A redirect to a bad address is accepted into pc and faults on the following cycle.
- Wrap-around: pc + 4 uses 32-bit modulo arithmetic. Reaching the top of memory causes FAULT through the range check, never a silent wrap to 0.
- redirect_valid in BOOT or FAULT is ignored.

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined:
  - Adds output ports perf_fetch_count (32) and perf_stall_count (32).
  - fetch_count increments on each fire.
  - stall_count increments each RUN cycle with id_valid && !id_ready.
  - Both counters are cleared by reset and wrap at 2^32.
- When undefined: the ports and counters are absent, and the rest of the behaviour is identical.

Decomposition:
- Shared package fetch_pkg holds:
  - the state enum (BOOT, RUN, FAULT)
  - constant INSTR_BYTES = 4
  - constant NOP_INSTR = 32'h0000_0013, used by decode on flush
- No sub-module required. The perf counters may optionally be a small sub-module, fetch_perf_counters, instantiated only under FETCH_PERF_EN.

Test Plan:
- Reset release, memory words 0..3 = A,B,C,D, id_ready = 1 -> BOOT for one cycle, then id_instr = A,B,C,D on consecutive cycles with id_pc = 0,4,8,12.
- id_ready held low for 3 cycles while id_instr = B at id_pc = 4 -> id_instr/id_pc/pc stable for 3 cycles; C appears the cycle after id_ready rises.
- redirect_valid with redirect_pc = 0x40 while id_ready = 0 -> next cycle id_valid = 0 and pc_address = 0x40; the following cycle id_pc = 0x40.
- redirect_pc = 0x42 -> fetch_fault = 1 two cycles later, id_valid stays 0, pc_address frozen at 0x42 until reset.
- Sequential fetch reaching pc = 0xFFC then 0x1000 -> word at 0xFFC delivered, then fetch_fault = 1 with no fetch at 0x1000.
- reset asserted mid-stream with id_valid = 1 -> next cycle id_valid = 0, pc_address = RESET_PC, fetch_fault = 0, and (with FETCH_PERF_EN) both counters = 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
//
// Purpose : Shared definitions for the instruction-fetch front end.
//           - fetch_state_t : controller state (BOOT, RUN, FAULT)
//           - INSTR_BYTES   : size of one instruction word in bytes
//           - NOP_INSTR     : canonical no-op that decode inserts on a flush
//           - word_aligned  : helper that tests a byte address for word alignment
// Ports   : none (package)
// ---------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    localparam int unsigned INSTR_BYTES = 4;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

    function automatic logic word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_perf_counters.sv
// ---------------------------------------------------------------------------
// fetch_perf_counters
//
// Purpose : Free-running 32-bit event counters for the fetch sequencer.
//           Only instantiated when the FETCH_PERF_EN macro is defined.
// Ports   :
//   clk          in   1   rising-edge clock
//   reset        in   1   synchronous active-high reset, clears both counters
//   fire         in   1   a fetch was registered into IF/ID this cycle
//   stall        in   1   IF/ID held a word that decode did not accept
//   fetch_count  out  32  number of fetches since reset (wraps at 2^32)
//   stall_count  out  32  number of stall cycles since reset (wraps at 2^32)
// ---------------------------------------------------------------------------
module fetch_perf_counters (
    input  logic        clk,
    input  logic        reset,
    input  logic        fire,
    input  logic        stall,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
);

    // Both counters simply roll over; software reads deltas.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count <= 32'd0;
            stall_count <= 32'd0;
        end else begin
            if (fire) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (stall) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//
// Purpose : Instruction-fetch controller. Owns the PC, addresses the
//           combinational-read instruction memory every cycle and registers
//           the returned word into the IF/ID stage behind a valid/ready
//           handshake. Handles redirects from execute, decode back-pressure
//           and fetch faults (misaligned or out-of-range PC).
//
// Optional feature macro : FETCH_PERF_EN
//           When defined, adds perf_fetch_count / perf_stall_count outputs.
//
// Ports   :
//   clk               in   1   rising-edge clock
//   reset             in   1   synchronous active-high reset
//   pc_address        out  32  byte address to instruction memory (= pc)
//   instruction       in   32  combinational read data from memory
//   redirect_valid    in   1   execute requests a PC change
//   redirect_pc       in   32  redirect target byte address
//   id_ready          in   1   decode can accept a word this cycle
//   id_valid          out  1   id_instr/id_pc hold a valid word
//   id_instr          out  32  registered instruction word
//   id_pc             out  32  PC of id_instr
//   fetch_fault       out  1   sticky fault flag
//   perf_fetch_count  out  32  (FETCH_PERF_EN) fetches since reset
//   perf_stall_count  out  32  (FETCH_PERF_EN) stall cycles since reset
// ---------------------------------------------------------------------------
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc_address,
    input  logic [31:0] instruction,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic        fetch_fault
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_count,
    output logic [31:0] perf_stall_count
`endif
);

    // One extra bit so IMEM_WORDS*4 cannot overflow the comparison.
    localparam logic [32:0] IMEM_BYTES = 33'(IMEM_WORDS) * 33'(INSTR_BYTES);

    fetch_state_t state;
    fetch_state_t state_next;
    logic [31:0]  pc;
    logic [31:0]  pc_next;
    logic         id_valid_next;
    logic [31:0]  id_instr_next;
    logic [31:0]  id_pc_next;
    logic         fault_next;
    logic         pc_ok;
    logic         fire;
    logic         stall;

    assign pc_address = pc;

    // A PC is fetchable only if word aligned and inside the memory. The
    // range check is what stops pc+4 from silently walking off the top.
    assign pc_ok = word_aligned(pc) && ({1'b0, pc} < IMEM_BYTES);

    // Stall: decode is holding off a word we already present.
    assign stall = (state == RUN) && id_valid && !id_ready;

    // Fire: the IF/ID slot is free (empty or being drained this cycle),
    // no redirect is overriding us and the PC is fetchable.
    assign fire = (state == RUN) && !redirect_valid
                  && (!id_valid || id_ready) && pc_ok;

    // Next-state and datapath decisions. Priority inside RUN is
    // redirect > stall > fetch > fault, so a bad PC can never overtake a
    // word that decode has not yet taken.
    always_comb begin
        state_next    = state;
        pc_next       = pc;
        id_valid_next = id_valid;
        id_instr_next = id_instr;
        id_pc_next    = id_pc;
        fault_next    = fetch_fault;

        case (state)
            BOOT: begin
                state_next = RUN;
            end

            RUN: begin
                if (redirect_valid) begin
                    id_valid_next = 1'b0;
                    pc_next       = redirect_pc;
                end else if (stall) begin
                    id_valid_next = 1'b1;
                end else if (fire) begin
                    id_valid_next = 1'b1;
                    id_instr_next = instruction;
                    id_pc_next    = pc;
                    pc_next       = pc + 32'(INSTR_BYTES);
                end else begin
                    id_valid_next = 1'b0;
                    fault_next    = 1'b1;
                    state_next    = FAULT;
                end
            end

            FAULT: begin
                id_valid_next = 1'b0;
                fault_next    = 1'b1;
            end

            default: begin
                state_next    = BOOT;
                id_valid_next = 1'b0;
            end
        endcase
    end

    // State and IF/ID registers. Reset wipes any held word and any
    // redirect that was in the middle of taking effect.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            id_valid    <= 1'b0;
            id_instr    <= 32'd0;
            id_pc       <= 32'd0;
            fetch_fault <= 1'b0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            id_valid    <= id_valid_next;
            id_instr    <= id_instr_next;
            id_pc       <= id_pc_next;
            fetch_fault <= fault_next;
        end
    end

`ifdef FETCH_PERF_EN
    fetch_perf_counters u_perf (
        .clk         (clk),
        .reset       (reset),
        .fire        (fire),
        .stall       (stall),
        .fetch_count (perf_fetch_count),
        .stall_count (perf_stall_count)
    );
`endif

endmodule
